// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use
// hazard detection. Feeds the ALU operands, the operation code and the store data.
module ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_alu_src,
    input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
    input  logic                      id_mem_read,
    input  logic                      id_reg_write,
    input  logic                      flush,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic                      exmem_reg_write,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic                      memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_valid,
    output logic                      hazard_stall
);

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO  = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]     DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [OPCODE_LENGTH-1:0]  OP_ZERO   = {OPCODE_LENGTH{1'b0}};

    logic                      valid_r;
    logic                      alu_src_r;
    logic                      mem_read_r;
    logic                      reg_write_r;
    logic [REG_ADDR_WIDTH-1:0] rs1_r;
    logic [REG_ADDR_WIDTH-1:0] rs2_r;
    logic [REG_ADDR_WIDTH-1:0] rd_r;
    logic [DATA_WIDTH-1:0]     rs1_data_r;
    logic [DATA_WIDTH-1:0]     rs2_data_r;
    logic [DATA_WIDTH-1:0]     imm_r;
    logic [OPCODE_LENGTH-1:0]  op_r;

    logic                      hazard_s;
    logic                      bubble_s;
    logic [DATA_WIDTH-1:0]     fwd_a_s;
    logic [DATA_WIDTH-1:0]     fwd_b_s;
    logic [DATA_WIDTH-1:0]     src_b_s;

    // Newest producer wins; register 0 is hardwired and never takes a bypass.
    function automatic logic [DATA_WIDTH-1:0] forward_sel(
        input logic [REG_ADDR_WIDTH-1:0] src_idx,
        input logic [DATA_WIDTH-1:0]     rf_val,
        input logic                      em_we,
        input logic [REG_ADDR_WIDTH-1:0] em_rd,
        input logic [DATA_WIDTH-1:0]     em_val,
        input logic                      mw_we,
        input logic [REG_ADDR_WIDTH-1:0] mw_rd,
        input logic [DATA_WIDTH-1:0]     mw_val
    );
        logic [DATA_WIDTH-1:0] sel_v;
        if (em_we && (em_rd != REG_ZERO) && (em_rd == src_idx)) begin
            sel_v = em_val;
        end else if (mw_we && (mw_rd != REG_ZERO) && (mw_rd == src_idx)) begin
            sel_v = mw_val;
        end else begin
            sel_v = rf_val;
        end
        return sel_v;
    endfunction

    // Load-use detection; rs2 is always compared, even when the instruction ignores it.
    always_comb begin
        hazard_s = valid_r & mem_read_r & (rd_r != REG_ZERO) & id_valid &
                   ((rd_r == id_rs1) | (rd_r == id_rs2));
        bubble_s = flush | hazard_s;
    end

    // Operand bypass network and immediate select for operand B.
    always_comb begin
        fwd_a_s = forward_sel(rs1_r, rs1_data_r, exmem_reg_write, exmem_rd, exmem_result,
                              memwb_reg_write, memwb_rd, memwb_result);
        fwd_b_s = forward_sel(rs2_r, rs2_data_r, exmem_reg_write, exmem_rd, exmem_result,
                              memwb_reg_write, memwb_rd, memwb_result);
        if (alu_src_r) begin
            src_b_s = imm_r;
        end else begin
            src_b_s = fwd_b_s;
        end
    end

    // ID/EX register: reset, then bubble on flush or stall, else capture ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r     <= 1'b0;
            alu_src_r   <= 1'b0;
            mem_read_r  <= 1'b0;
            reg_write_r <= 1'b0;
            rs1_r       <= REG_ZERO;
            rs2_r       <= REG_ZERO;
            rd_r        <= REG_ZERO;
            rs1_data_r  <= DATA_ZERO;
            rs2_data_r  <= DATA_ZERO;
            imm_r       <= DATA_ZERO;
            op_r        <= OP_ZERO;
        end else if (bubble_s) begin
            valid_r     <= 1'b0;
            alu_src_r   <= 1'b0;
            mem_read_r  <= 1'b0;
            reg_write_r <= 1'b0;
            rs1_r       <= REG_ZERO;
            rs2_r       <= REG_ZERO;
            rd_r        <= REG_ZERO;
            rs1_data_r  <= DATA_ZERO;
            rs2_data_r  <= DATA_ZERO;
            imm_r       <= DATA_ZERO;
            op_r        <= OP_ZERO;
        end else begin
            valid_r     <= id_valid;
            alu_src_r   <= id_alu_src;
            mem_read_r  <= id_mem_read;
            reg_write_r <= id_reg_write;
            rs1_r       <= id_rs1;
            rs2_r       <= id_rs2;
            rd_r        <= id_rd;
            rs1_data_r  <= id_rs1_data;
            rs2_data_r  <= id_rs2_data;
            imm_r       <= id_imm;
            op_r        <= id_alu_op;
        end
    end

    assign SrcA          = fwd_a_s;
    assign SrcB          = src_b_s;
    assign ex_store_data = fwd_b_s;
    assign Operation     = op_r;
    assign ex_rd         = rd_r;
    assign ex_reg_write  = reg_write_r;
    assign ex_mem_read   = mem_read_r;
    assign ex_valid      = valid_r;
    assign hazard_stall  = hazard_s;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed vector table, hand-written hazard/flush/reset
// sequences, then randomized traffic against a pipeline-level reference model.
module tb_ex_operand_stage;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid, id_alu_src, id_mem_read, id_reg_write, flush;
    logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic [OW-1:0] id_alu_op;
    logic [AW-1:0] exmem_rd, memwb_rd;
    logic          exmem_reg_write, memwb_reg_write;
    logic [DW-1:0] exmem_result, memwb_result;
    logic [DW-1:0] SrcA, SrcB, ex_store_data;
    logic [OW-1:0] Operation;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_write, ex_mem_read, ex_valid, hazard_stall;

    ex_operand_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .flush(flush), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .memwb_result(memwb_result), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_valid(ex_valid), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_alu_src = 1'b0; id_mem_read = 1'b0; id_reg_write = 1'b0;
        id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_alu_op = 4'd0; flush = 1'b0;
        exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_result = 32'd0;
        memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_result = 32'd0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ex_valid"},     32'(ex_valid), 32'd0);
        chk({tag, " SrcA"},         SrcA, 32'd0);
        chk({tag, " SrcB"},         SrcB, 32'd0);
        chk({tag, " Operation"},    32'(Operation), 32'd0);
        chk({tag, " store"},        ex_store_data, 32'd0);
        chk({tag, " ex_rd"},        32'(ex_rd), 32'd0);
        chk({tag, " ex_reg_write"}, 32'(ex_reg_write), 32'd0);
        chk({tag, " ex_mem_read"},  32'(ex_mem_read), 32'd0);
        chk({tag, " hazard_stall"}, 32'(hazard_stall), 32'd0);
    endtask

    // Reference model: the instruction currently sitting in EX, as a plain record.
    typedef struct {
        logic          v;
        logic [AW-1:0] rs1, rs2, rd;
        logic [DW-1:0] a, b, imm;
        logic          src;
        logic [OW-1:0] op;
        logic          mr, rw;
    } ex_t;

    ex_t m, nxt;

    function automatic logic [DW-1:0] model_operand(input logic [AW-1:0] idx, input logic [DW-1:0] rf);
        if (idx == 5'd0) return rf;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_result;
        return rf;
    endfunction

    task automatic chk_model();
        logic          stall;
        logic [DW-1:0] b_val;
        stall = m.v && m.mr && (m.rd != 5'd0) && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
        b_val = model_operand(m.rs2, m.b);
        chk("rnd SrcA",      SrcA, model_operand(m.rs1, m.a));
        chk("rnd SrcB",      SrcB, m.src ? m.imm : b_val);
        chk("rnd store",     ex_store_data, b_val);
        chk("rnd Operation", 32'(Operation), 32'(m.op));
        chk("rnd ex_rd",     32'(ex_rd), 32'(m.rd));
        chk("rnd ex_valid",  32'(ex_valid), 32'(m.v));
        chk("rnd ex_rw",     32'(ex_reg_write), 32'(m.rw));
        chk("rnd ex_mr",     32'(ex_mem_read), 32'(m.mr));
        chk("rnd stall",     32'(hazard_stall), 32'(stall));
        if (flush || stall) begin
            nxt = '{1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0};
        end else begin
            nxt = '{id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
                    id_alu_src, id_alu_op, id_mem_read, id_reg_write};
        end
    endtask

    typedef struct {
        logic          v;
        logic [AW-1:0] rs1, rs2, rd;
        logic [DW-1:0] d1, d2, imm;
        logic          src;
        logic [OW-1:0] op;
        logic [AW-1:0] xrd;  logic xwe; logic [DW-1:0] xres;
        logic [AW-1:0] wrd;  logic wwe; logic [DW-1:0] wres;
        logic [DW-1:0] e_a, e_b, e_st;
        logic [OW-1:0] e_op;
        logic          e_v;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 4'b0001,
                   5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd5, 32'd7, 32'd7, 4'b0001, 1'b1};
        tbl[1] = '{1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'hFFFF_FFFC, 1'b1, 4'b0001,
                   5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd5, 32'hFFFF_FFFC, 32'd7, 4'b0001, 1'b1};
        tbl[2] = '{1'b1, 5'd3, 5'd4, 5'd8, 32'h11, 32'h9, 32'd0, 1'b0, 4'b0010,
                   5'd3, 1'b1, 32'h100, 5'd3, 1'b1, 32'h200, 32'h100, 32'h9, 32'h9, 4'b0010, 1'b1};
        tbl[3] = '{1'b1, 5'd3, 5'd4, 5'd8, 32'h11, 32'h9, 32'd0, 1'b0, 4'b0010,
                   5'd3, 1'b0, 32'h100, 5'd3, 1'b1, 32'h200, 32'h200, 32'h9, 32'h9, 4'b0010, 1'b1};
        tbl[4] = '{1'b1, 5'd3, 5'd4, 5'd8, 32'h11, 32'h9, 32'd0, 1'b0, 4'b0010,
                   5'd3, 1'b0, 32'h100, 5'd3, 1'b0, 32'h200, 32'h11, 32'h9, 32'h9, 4'b0010, 1'b1};
        tbl[5] = '{1'b1, 5'd0, 5'd4, 5'd8, 32'd0, 32'h9, 32'd0, 1'b0, 4'b0011,
                   5'd0, 1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'hCAFE_F00D, 32'd0, 32'h9, 32'h9, 4'b0011, 1'b1};
        tbl[6] = '{1'b1, 5'd1, 5'd6, 5'd2, 32'd5, 32'h55, 32'd0, 1'b0, 4'b0100,
                   5'd6, 1'b1, 32'hAAA, 5'd0, 1'b0, 32'd0, 32'd5, 32'hAAA, 32'hAAA, 4'b0100, 1'b1};
        tbl[7] = '{1'b1, 5'd1, 5'd6, 5'd2, 32'd5, 32'h55, 32'h10, 1'b1, 4'b0101,
                   5'd0, 1'b0, 32'd0, 5'd6, 1'b1, 32'hBBB, 32'd5, 32'h10, 32'hBBB, 4'b0101, 1'b1};
        tbl[8] = '{1'b0, 5'd1, 5'd2, 5'd3, 32'h77, 32'h88, 32'd0, 1'b0, 4'b0110,
                   5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'h77, 32'h88, 32'h88, 4'b0110, 1'b0};

        // Reset held, then released with no capture yet.
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_zero("rst held");
        @(negedge clk) reset = 1'b0;
        #1 chk_zero("rst released");
        @(posedge clk); #1;

        // Directed vector table: capture at one edge, check forwarding on the next cycle.
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            id_valid = tbl[i].v; id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; id_rd = tbl[i].rd;
            id_rs1_data = tbl[i].d1; id_rs2_data = tbl[i].d2; id_imm = tbl[i].imm;
            id_alu_src = tbl[i].src; id_alu_op = tbl[i].op; id_reg_write = 1'b1;
            @(posedge clk); #1;
            id_valid = 1'b0;
            exmem_rd = tbl[i].xrd; exmem_reg_write = tbl[i].xwe; exmem_result = tbl[i].xres;
            memwb_rd = tbl[i].wrd; memwb_reg_write = tbl[i].wwe; memwb_result = tbl[i].wres;
            #2;
            chk($sformatf("vec%0d SrcA", i),      SrcA, tbl[i].e_a);
            chk($sformatf("vec%0d SrcB", i),      SrcB, tbl[i].e_b);
            chk($sformatf("vec%0d store", i),     ex_store_data, tbl[i].e_st);
            chk($sformatf("vec%0d Operation", i), 32'(Operation), 32'(tbl[i].e_op));
            chk($sformatf("vec%0d ex_valid", i),  32'(ex_valid), 32'(tbl[i].e_v));
        end

        // Load-use: load rd=5 in EX, dependent on rs2 in ID.
        idle_inputs();
        id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd5; id_alu_op = 4'b0111;
        @(posedge clk); #1;
        idle_inputs();
        id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd5; id_rd = 5'd9; id_reg_write = 1'b1;
        id_rs1_data = 32'h1234; id_alu_op = 4'b1000;
        #1 chk("lu stall", 32'(hazard_stall), 32'd1);
        chk("lu ex_mem_read", 32'(ex_mem_read), 32'd1);
        @(posedge clk); #1;
        chk("lu bubble valid", 32'(ex_valid), 32'd0);
        chk("lu bubble rw",    32'(ex_reg_write), 32'd0);
        chk("lu bubble op",    32'(Operation), 32'd0);
        chk("lu bubble SrcA",  SrcA, 32'd0);
        chk("lu stall gone",   32'(hazard_stall), 32'd0);
        @(posedge clk); #1;
        chk("lu dep valid", 32'(ex_valid), 32'd1);
        chk("lu dep SrcA",  SrcA, 32'h1234);
        chk("lu dep op",    32'(Operation), 32'b1000);

        // Load writing x0 must not stall.
        idle_inputs();
        id_valid = 1'b1; id_mem_read = 1'b1; id_rd = 5'd0;
        @(posedge clk); #1;
        id_mem_read = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1 chk("x0 load stall", 32'(hazard_stall), 32'd0);

        // Flush kills a valid ID instruction.
        idle_inputs();
        id_valid = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1; id_rd = 5'd7; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush valid", 32'(ex_valid), 32'd0);
        chk("flush rw",    32'(ex_reg_write), 32'd0);
        chk("flush mr",    32'(ex_mem_read), 32'd0);

        // Flush together with a load-use stall: one bubble, stall still visible.
        idle_inputs();
        id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd4;
        @(posedge clk); #1;
        idle_inputs();
        id_valid = 1'b1; id_rs1 = 5'd4; id_rd = 5'd2; id_reg_write = 1'b1; flush = 1'b1;
        #1 chk("fs stall", 32'(hazard_stall), 32'd1);
        @(posedge clk); #1;
        chk("fs bubble valid", 32'(ex_valid), 32'd0);
        chk("fs bubble rd",    32'(ex_rd), 32'd0);

        // Asynchronous reset while EX holds a valid load that would stall ID.
        idle_inputs();
        id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd5;
        id_rs1_data = 32'h55; id_alu_op = 4'b0011;
        @(posedge clk); #1;
        id_rs1 = 5'd5; id_mem_read = 1'b0;
        #1 chk("pre-rst valid", 32'(ex_valid), 32'd1);
        reset = 1'b1;
        #1 chk_zero("mid rst");
        @(negedge clk) reset = 1'b0;
        idle_inputs();

        // Randomized traffic versus the model.
        m = '{1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0};
        @(posedge clk); #1;
        for (int c = 0; c < 400; c++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs1       = 5'($urandom_range(0, 7));
            id_rs2       = 5'($urandom_range(0, 7));
            id_rd        = 5'($urandom_range(0, 7));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_imm       = $urandom;
            id_alu_src   = 1'($urandom_range(0, 1));
            id_alu_op    = 4'($urandom_range(0, 15));
            id_mem_read  = ($urandom_range(0, 2) == 0);
            id_reg_write = 1'($urandom_range(0, 1));
            flush        = ($urandom_range(0, 9) == 0);
            exmem_rd        = 5'($urandom_range(0, 7));
            exmem_reg_write = 1'($urandom_range(0, 1));
            exmem_result    = $urandom;
            memwb_rd        = 5'($urandom_range(0, 7));
            memwb_reg_write = 1'($urandom_range(0, 1));
            memwb_result    = $urandom;
            @(negedge clk);
            chk_model();
            @(posedge clk);
            m = nxt;
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register plus operand forwarding and load-use hazard detection, directly upstream of the ALU. Captures decoded operands and control from ID each cycle. Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, then drives SrcA/SrcB/Operation into the ALU. Asserts a stall request on load-use hazards and inserts a bubble.

Parameters:
DATA_WIDTH, 32, operand/result width
OPCODE_LENGTH, 4, ALU Operation width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs1_data  in  DATA_WIDTH  register file read value, rs1
id_rs2_data  in  DATA_WIDTH  register file read value, rs2
id_imm  in  DATA_WIDTH  sign-extended immediate
id_rs1  in  REG_ADDR_WIDTH  rs1 index
id_rs2  in  REG_ADDR_WIDTH  rs2 index
id_rd  in  REG_ADDR_WIDTH  destination index
id_alu_src  in  1  1 = SrcB takes immediate
id_alu_op  in  OPCODE_LENGTH  ALU operation code
id_mem_read  in  1  instruction is a load
id_reg_write  in  1  instruction writes rd
flush  in  1  kill the instruction entering EX (taken branch/jump)
exmem_rd  in  REG_ADDR_WIDTH  EX/MEM destination
exmem_reg_write  in  1  EX/MEM writes rd
exmem_result  in  DATA_WIDTH  EX/MEM ALU result
memwb_rd  in  REG_ADDR_WIDTH  MEM/WB destination
memwb_reg_write  in  1  MEM/WB writes rd
memwb_result  in  DATA_WIDTH  MEM/WB writeback value
SrcA  out  DATA_WIDTH  ALU operand A
SrcB  out  DATA_WIDTH  ALU operand B
Operation  out  OPCODE_LENGTH  ALU operation
ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
ex_rd  out  REG_ADDR_WIDTH  registered rd
ex_reg_write  out  1  registered reg_write
ex_mem_read  out  1  registered mem_read
ex_valid  out  1  EX holds a real instruction
hazard_stall  out  1  freeze PC and IF/ID this cycle

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous, active-high.
- Reset: every ID/EX register cleared to 0, including valid, op and rd. SrcA, SrcB, Operation, ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_valid and hazard_stall all read 0 while reset is held and after release until the first capture.
- Hazard detection (combinational):
  - hazard_stall = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
  - The check is conservative: rs2 is compared even for I-type instructions.
- Register update each rising edge, priority order:
  - reset.
  - flush: load bubble.
  - hazard_stall: load bubble.
  - Otherwise: capture all id_* fields, with ex_valid = id_valid.
- Bubble contents: valid=0, reg_write=0, mem_read=0, rd=0, rs1=0, rs2=0, op=0, operands=0.
- flush and hazard_stall together: bubble. hazard_stall stays combinational and is not masked by flush; upstream gives flush priority.
- Capture latency: 1 cycle from ID inputs to EX outputs.
- Forwarding (combinational, per source, using the registered rs1/rs2):
  - EX/MEM is selected if exmem_reg_write & exmem_rd != 0 & exmem_rd == rs.
  - Else MEM/WB is selected if memwb_reg_write & memwb_rd != 0 & memwb_rd == rs.
  - Else the registered register-file value is used.
  - EX/MEM has priority when both match.
  - Index 0 never forwards.
- Operand outputs:
  - SrcA = forwarded rs1.
  - fwdB = forwarded rs2.
  - SrcB = alu_src ? registered imm : fwdB.
  - ex_store_data = fwdB, always, regardless of alu_src.
  - Operation = registered op.
- Bubble outputs: forwarding is inert because rs=0, so SrcA=SrcB=0 and Operation=0000.
- No output depends on id_* inputs combinationally except hazard_stall.

Test Plan:
- Assert reset mid-operation while EX holds a valid instruction → same cycle: ex_valid=0, SrcA=0, SrcB=0, Operation=0, hazard_stall=0.
- ID: rs1_data=5, rs2_data=7, alu_op=0001, alu_src=0, valid=1 → next cycle SrcA=5, SrcB=7, Operation=0001, ex_valid=1. Repeat with alu_src=1, imm=0xFFFFFFFC → SrcB=0xFFFFFFFC, ex_store_data=7.
- EX rs1=3; exmem_rd=3 reg_write=1 result=0x100; memwb_rd=3 reg_write=1 result=0x200 → SrcA=0x100. Drop exmem_reg_write → SrcA=0x200. Drop both → SrcA = captured rs1_data.
- EX rs1=0 with rs1_data=0; exmem_rd=0, reg_write=1, result=0xDEADBEEF → SrcA=0.
- EX holds load rd=5 (mem_read=1, valid=1); ID valid with rs2=5 → hazard_stall=1 that cycle. Next cycle ex_valid=0, ex_reg_write=0, Operation=0. Then with the load gone, hazard_stall=0 and the dependent instruction is captured.
- flush=1 with a valid ID instruction → next cycle ex_valid=0, ex_reg_write=0, ex_mem_read=0. flush=1 and hazard_stall=1 together → single bubble; no capture.
